// File: rtl/pc_gen.sv
// Program counter generator: trap, redirect, return-stack and sequential
// next-PC selection with a circular return-address stack.
module pc_gen #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 'h01000000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h00000100,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            trap_valid,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_target,
    input  logic            call,
    input  logic            ret,
    output logic [XLEN-1:0] pc,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            misalign,
    output logic            ras_underflow
);

    localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(RAS_DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

    logic [XLEN-1:0] r_ras [RAS_DEPTH];
    logic [XLEN-1:0] r_pc;
    logic [PW-1:0]   r_top;
    logic [CW-1:0]   r_cnt;
    logic            r_mis;
    logic            r_uf;

    logic [XLEN-1:0] w_seq;
    logic [XLEN-1:0] w_pc_nxt;
    logic [PW-1:0]   w_top_inc;
    logic [PW-1:0]   w_top_dec;
    logic [PW-1:0]   w_top_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_mis_nxt;
    logic            w_uf_nxt;
    logic            w_pop;
    logic            w_wr;
    logic [PW-1:0]   w_wr_idx;

    assign w_seq     = r_pc + XLEN'(4);
    assign w_top_inc = (r_top == LAST) ? '0 : r_top + PW'(1);
    assign w_top_dec = (r_top == '0) ? LAST : r_top - PW'(1);

    assign pc            = r_pc;
    assign ras_empty     = (r_cnt == '0);
    assign ras_full      = (r_cnt == FULL);
    assign misalign      = r_mis;
    assign ras_underflow = r_uf;

    always_comb begin
        w_pc_nxt  = w_seq;
        w_top_nxt = r_top;
        w_cnt_nxt = r_cnt;
        w_mis_nxt = 1'b0;
        w_uf_nxt  = 1'b0;
        w_pop     = 1'b0;
        w_wr      = 1'b0;
        w_wr_idx  = r_top;
        if (trap_valid) begin
            w_pc_nxt  = TRAP_VECTOR;
            w_cnt_nxt = '0;
        end else begin
            w_pop    = ret && !redir_valid && !ras_empty;
            w_uf_nxt = ret && !redir_valid && ras_empty;
            if (redir_valid) begin
                w_pc_nxt  = {redir_target[XLEN-1:2], 2'b00};
                w_mis_nxt = |redir_target[1:0];
            end else if (w_pop) begin
                w_pc_nxt = r_ras[r_top];
            end
            // Call with a pop rewrites the top in place, so depth is unchanged
            if (call && w_pop) begin
                w_wr = 1'b1;
            end else if (call) begin
                w_wr      = 1'b1;
                w_wr_idx  = w_top_inc;
                w_top_nxt = w_top_inc;
                if (!ras_full) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end else if (w_pop) begin
                w_top_nxt = w_top_dec;
                w_cnt_nxt = r_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc  <= RESET_VECTOR;
            r_top <= '0;
            r_cnt <= '0;
            r_mis <= 1'b0;
            r_uf  <= 1'b0;
        end else if (en) begin
            r_pc  <= w_pc_nxt;
            r_top <= w_top_nxt;
            r_cnt <= w_cnt_nxt;
            r_mis <= w_mis_nxt;
            r_uf  <= w_uf_nxt;
        end
    end

    // Entry contents need no reset; the count alone marks them valid
    always_ff @(posedge clk) begin
        if (en && w_wr) begin
            r_ras[w_wr_idx] <= w_seq;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed scenarios plus random traffic
// checked against a queue-based return-stack model.
module tb_pc_gen;

    localparam logic [31:0] RV = 32'h01000000;
    localparam logic [31:0] TV = 32'h00000100;
    localparam int          D  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        trap_valid = 1'b0;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_target = '0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [31:0] pc;
    logic        ras_empty;
    logic        ras_full;
    logic        misalign;
    logic        ras_underflow;

    pc_gen #(
        .XLEN(32),
        .RESET_VECTOR(RV),
        .TRAP_VECTOR(TV),
        .RAS_DEPTH(D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .trap_valid(trap_valid),
        .redir_valid(redir_valid),
        .redir_target(redir_target),
        .call(call),
        .ret(ret),
        .pc(pc),
        .ras_empty(ras_empty),
        .ras_full(ras_full),
        .misalign(misalign),
        .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        emp;
        logic        full;
        logic        mis;
        logic        uf;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;

    logic [31:0] m_pc = RV;
    logic [31:0] m_ras[$];
    logic        m_mis = 1'b0;
    logic        m_uf = 1'b0;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
        end
    endtask

    task automatic m_reset();
        m_pc = RV;
        m_ras.delete();
        m_mis = 1'b0;
        m_uf = 1'b0;
    endtask

    task automatic m_step(input bit e, input bit t, input bit r,
                          input logic [31:0] tg, input bit c, input bit rt);
        logic [31:0] seq;
        logic [31:0] nxt;
        if (!e) return;
        if (t) begin
            m_pc = TV;
            m_ras.delete();
            m_mis = 1'b0;
            m_uf = 1'b0;
            return;
        end
        seq = m_pc + 32'd4;
        nxt = seq;
        m_mis = 1'b0;
        m_uf = 1'b0;
        if (r) begin
            nxt = {tg[31:2], 2'b00};
            m_mis = (tg[1:0] != 2'b00);
        end else if (rt) begin
            if (m_ras.size() > 0) nxt = m_ras.pop_back();
            else m_uf = 1'b1;
        end
        if (c) begin
            m_ras.push_back(seq);
            if (m_ras.size() > D) void'(m_ras.pop_front());
        end
        m_pc = nxt;
    endtask

    task automatic cyc(input bit e, input bit t, input bit r,
                       input logic [31:0] tg, input bit c, input bit rt);
        exp_t x;
        @(negedge clk);
        en = e;
        trap_valid = t;
        redir_valid = r;
        redir_target = tg;
        call = c;
        ret = rt;
        m_step(e, t, r, tg, c, rt);
        x.pc = m_pc;
        x.emp = (m_ras.size() == 0);
        x.full = (m_ras.size() == D);
        x.mis = m_mis;
        x.uf = m_uf;
        sb.push_back(x);
        @(posedge clk);
        #2;
        en = 1'b0;
        trap_valid = 1'b0;
        redir_valid = 1'b0;
        call = 1'b0;
        ret = 1'b0;
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("sb_pc", pc, x.pc);
                chk("sb_empty", 32'(ras_empty), 32'(x.emp));
                chk("sb_full", 32'(ras_full), 32'(x.full));
                chk("sb_mis", 32'(misalign), 32'(x.mis));
                chk("sb_uf", 32'(ras_underflow), 32'(x.uf));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rets [4];
        rets[0] = 32'h504;
        rets[1] = 32'h404;
        rets[2] = 32'h304;
        rets[3] = 32'h204;

        #1 rst = 1'b0;
        #1;
        chk("rst_pc", pc, RV);
        chk("rst_empty", 32'(ras_empty), 32'd1);
        chk("rst_uf", 32'(ras_underflow), 32'd0);
        m_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        chk("r32_pc0", pc, RV);

        for (int i = 1; i <= 3; i++) begin
            cyc(1, 0, 0, '0, 0, 0);
            chk("r32_pc", pc, RV + 32'(4 * i));
        end
        chk("r32_empty", 32'(ras_empty), 32'd1);

        cyc(1, 0, 1, 32'h02000006, 0, 0);
        chk("r33_pc", pc, 32'h02000004);
        chk("r33_mis", 32'(misalign), 32'd1);
        cyc(1, 0, 0, '0, 0, 0);
        chk("r33_mis_clr", 32'(misalign), 32'd0);

        cyc(1, 0, 1, 32'hFFFFFFFC, 0, 0);
        cyc(1, 0, 0, '0, 0, 0);
        chk("wrap_pc", pc, 32'h0);

        cyc(1, 0, 1, 32'h100, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            cyc(1, 0, 1, 32'((i + 1) * 32'h100), 1, 0);
        end
        chk("r34_full", 32'(ras_full), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, '0, 0, 1);
            chk("r34_ret_pc", pc, rets[i]);
        end
        cyc(1, 0, 0, '0, 0, 1);
        chk("r34_uf_pc", pc, 32'h208);
        chk("r34_uf", 32'(ras_underflow), 32'd1);
        cyc(0, 0, 0, '0, 0, 0);
        chk("uf_hold", 32'(ras_underflow), 32'd1);
        cyc(1, 0, 0, '0, 0, 0);
        chk("uf_clr", 32'(ras_underflow), 32'd0);

        cyc(1, 0, 1, 32'h1000, 0, 0);
        cyc(1, 0, 1, 32'h2000, 1, 0);
        cyc(1, 0, 0, '0, 1, 1);
        chk("r35_pc", pc, 32'h1004);
        chk("r35_cnt", 32'(ras_empty), 32'd0);
        cyc(1, 0, 0, '0, 0, 1);
        chk("r35_top", pc, 32'h2004);
        chk("r35_empty", 32'(ras_empty), 32'd1);

        cyc(1, 0, 0, '0, 1, 0);
        cyc(1, 0, 0, '0, 1, 0);
        cyc(1, 1, 1, 32'h4444, 0, 1);
        chk("r36_pc", pc, TV);
        chk("r36_empty", 32'(ras_empty), 32'd1);

        cyc(1, 0, 0, '0, 1, 0);
        cyc(1, 0, 0, '0, 1, 0);
        @(negedge clk);
        en = 1'b1;
        redir_valid = 1'b1;
        redir_target = 32'h3000;
        #2 rst = 1'b0;
        #1;
        chk("r37_pc", pc, RV);
        chk("r37_empty", 32'(ras_empty), 32'd1);
        m_reset();
        en = 1'b0;
        redir_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        cyc(0, 0, 1, 32'h3000, 1, 0);
        cyc(0, 0, 0, '0, 0, 1);
        chk("r37_hold", pc, RV);
        cyc(1, 0, 0, '0, 0, 0);
        chk("r37_first", pc, RV + 32'd4);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] tg;
            tg = $urandom();
            if ($urandom_range(0, 7) == 0) tg = 32'hFFFFFFF0 | (tg & 32'hF);
            cyc($urandom_range(0, 9) != 0,
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 5) == 0,
                tg,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 2) == 0);
        end

        if (sb.size() != 0) begin
            chk("sb_drain", 32'(sb.size()), 32'd0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32, width of every address port and of the PC register.
REQ-002 Parameter RESET_VECTOR, default 32'h01000000, PC value loaded on reset.
REQ-003 Parameter TRAP_VECTOR, default 32'h00000100, PC value loaded on trap.
REQ-004 Parameter RAS_DEPTH, default 4, number of return-address-stack entries; legal range 2..16.
REQ-005 clk  in  1  sole clock; all state updates occur on its rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-low.
REQ-007 en  in  1  advance enable; when 0, all state holds and all other inputs are ignored.
REQ-008 trap_valid  in  1  force the next PC to TRAP_VECTOR.
REQ-009 redir_valid  in  1  branch/jump taken.
REQ-010 redir_target  in  XLEN  branch/jump target address.
REQ-011 call  in  1  push PC+4 onto the RAS.
REQ-012 ret  in  1  pop the RAS top into the PC.
REQ-013 pc  out  XLEN  current PC (registered).
REQ-014 ras_empty  out  1  RAS holds 0 entries (combinational from count).
REQ-015 ras_full  out  1  RAS holds RAS_DEPTH entries (combinational from count).
REQ-016 misalign  out  1  registered flag: the last accepted redirect target had bits [1:0] != 0.
REQ-017 ras_underflow  out  1  registered one-cycle pulse: ret was accepted while RAS was empty.

Function
REQ-018 All updates SHALL occur only on a rising clk edge with en=1; with en=0 pc, RAS, count, misalign and ras_underflow SHALL hold (ras_underflow also holds).
REQ-019 Next-PC priority SHALL be: trap_valid > redir_valid > ret > sequential (pc+4); latency is one cycle from input sampling to new pc.
REQ-020 Sequential increment SHALL be modulo 2^XLEN; pc = all-ones-minus-3 SHALL wrap to 0.
REQ-021 Redirect SHALL load {redir_target[XLEN-1:2],2'b00}; misalign SHALL be set to (redir_target[1:0]!=0) on each accepted redirect and cleared on any other accepted advance.
REQ-022 ret without higher-priority event and RAS non-empty SHALL load pc from the RAS top and decrement the count.
REQ-023 ret with RAS empty SHALL fall through to pc+4 and pulse ras_underflow for exactly one cycle; count stays 0.
REQ-024 call SHALL push pc+4 (the value current before the edge) and increment the count, regardless of which next-PC source wins, except when trap_valid=1.
REQ-025 call when full SHALL overwrite the oldest entry (circular wrap); count stays RAS_DEPTH; no error flag.
REQ-026 call and ret in the same cycle SHALL replace the top entry with pc+4 and load pc from the old top (count unchanged); if empty, behave as call plus underflow pulse with pc+4 loaded.
REQ-027 trap_valid=1 SHALL flush the RAS (count 0) and suppress call/ret effects that cycle.
REQ-028 The RAS SHALL be implemented as a circular buffer with a ceil(log2(RAS_DEPTH))-bit top pointer and a separate count register.

Reset
REQ-029 rst=0 SHALL immediately and asynchronously force pc=RESET_VECTOR, count=0, misalign=0, ras_underflow=0, regardless of clk or en.
REQ-030 RAS entry contents SHALL be don't-care after reset; only the count gates validity.
REQ-031 Reset deassertion SHALL take effect at the next rising clk edge; the first advance yields RESET_VECTOR+4.

Verification
REQ-032 Reset then 3 cycles en=1, no events -> pc 32'h01000000, 01000004, 01000008, 0100000C; ras_empty=1.
REQ-033 redir_valid=1, redir_target=32'h02000006 -> next pc 32'h02000004, misalign=1; following plain advance -> misalign=0.
REQ-034 Five calls at pc 0x100,0x200,0x300,0x400,0x500 (RAS_DEPTH=4) then five rets -> pc 0x504,0x404,0x304,0x204, then pc+4 with ras_underflow pulse.
REQ-035 call+ret same cycle with top 0x1004, pc 0x2000 -> pc 0x1004, new top 0x2004, count unchanged.
REQ-036 trap_valid with redir_valid and ret asserted, RAS count 2 -> pc TRAP_VECTOR, ras_empty=1.
REQ-037 rst pulsed low mid-cycle while en=1 and redirect pending -> pc=RESET_VECTOR before next edge, count 0; en=0 for 2 cycles afterwards -> pc holds.
